onehot_wr_sequencer: RTL and testbench
======================================

// Module: onehot_wr_sequencer
// PURPOSE
//  Parametrised successor to the 4-to-16 write-enable decoder in the register-file path.
//  Accepts write requests (address, beat count, mode) over a valid/ready handshake.
//  Drives a registered one-hot write-enable vector per beat: single, incrementing burst with wrap, or broadcast.
//  Sits between the write-port controller and the register bank's per-register enables.
// PARAMETERS
//  ADDR_W   4   address width; OUT_W = 1<<ADDR_W one-hot lines (localparam, not overridable)
//  LEN_W    4   beat-count width; req_len = beats-1, so max burst is 2**LEN_W beats
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       sequencer can accept a request
//  req_addr    in   ADDR_W  start address
//  req_len     in   LEN_W   beats minus one (ignored for single mode)
//  req_mode    in   2       00 single, 01 burst-incr, 10 broadcast, 11 reserved
//  wrt_enable  in   1       global write gate; low stalls the sequence
//  out         out  OUT_W   registered write-enable vector
//  out_valid   out  1       out carries a live beat this cycle
//  busy        out  1       request in progress (state != IDLE)
//  err         out  1       sticky: reserved/unsupported mode received; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, out=0, out_valid=0, busy=0, err=0, req_ready=1, internal addr/count=0.
//  FSM states: IDLE, RUN.
//  req_ready = (state==IDLE); accept = req_valid & req_ready. Accept latches addr, len, mode.
//  IDLE->RUN on accept of a supported mode. Reserved mode: dropped, err<=1, stays IDLE, no beat.
//  First beat appears on out the cycle after accept (latency 1), if wrt_enable is high that cycle.
//  Beat cycle (RUN & wrt_enable): single: out = 1<<addr. burst: out = 1<<addr.
//   broadcast: out = all ones. Each beat sets out_valid=1.
//  Stall cycle (RUN & !wrt_enable): out=0, out_valid=0; addr and count held; no beat consumed.
//  Burst: addr increments mod 2**ADDR_W after each beat (15 -> 0 at ADDR_W=4); count decrements.
//  RUN->IDLE after final beat: single/broadcast after 1 beat; burst after req_len+1 beats.
//  req_ready rises the cycle after the final beat; out returns to 0 that cycle unless a beat issues.
//  No back-to-back overlap: a new request is accepted no earlier than the cycle after the last beat.
//  req_len=0 in burst mode: exactly one beat, identical to single.
//  Invariant: out is either 0 or exactly one-hot, except broadcast beats (all ones).
//  rst asserted mid-burst: immediate asynchronous clear to reset values; remaining beats discarded.
//  req_valid while busy: ignored (req_ready=0); requester must hold.
// CONFIGURATION
//  Macro ONEHOT_WR_BROADCAST_EN:
//   defined: mode 10 supported as above.
//   undefined: mode 10 treated as reserved (dropped, err<=1); broadcast logic not synthesised.
// STRUCTURE
//  Shared package onehot_wr_pkg: mode enum (MODE_SINGLE, MODE_BURST, MODE_BCAST, MODE_RSVD),
//   FSM state enum (ST_IDLE, ST_RUN).
//  One sub-module: onehot_dec (pure combinational ADDR_W -> OUT_W decoder with enable),
//   instantiated once; sequencer registers its output.
// TESTING
//  1 Reset: assert rst mid-run -> out=0, out_valid=0, busy=0, req_ready=1, err=0 immediately.
//  2 Single: addr=5, mode=00, wrt_enable=1 -> next cycle out=16'h0020, out_valid=1; following cycle req_ready=1.
//  3 Burst wrap: addr=14, len=3, mode=01 -> out 16'h4000, 16'h8000, 16'h0001, 16'h0002 on 4 cycles, then idle.
//  4 Stall: burst addr=2, len=2; drop wrt_enable for 2 cycles after first beat
//     -> out 16'h0004, 0, 0, 16'h0008, 16'h0010; total 3 beats.
//  5 Broadcast: mode=10 with ONEHOT_WR_BROADCAST_EN -> out=16'hFFFF one cycle.
//     Without macro -> no beat, err=1, req_ready stays 1.
//  6 Reserved + hold: mode=11 -> err=1 sticky. Then req_valid held high while busy -> second request taken only after the first completes.

Source files
------------

// File: rtl/onehot_wr_sequencer_pkg.sv
// Shared types for the one-hot write-enable sequencer: request modes and FSM states.
// Pure type definitions; no latency or backpressure of its own.
package onehot_wr_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_BURST  = 2'b01,
    MODE_BCAST  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_wr_sequencer_if.sv
// Request handshake plus write-enable outputs of the sequencer; the requester uses master.
// req_valid must be held until req_ready is seen high.
interface onehot_wr_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
);
  localparam int OUT_W = 1 << ADDR_W;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [1:0]        req_mode;
  logic              wrt_enable;
  logic [OUT_W-1:0]  out;
  logic              out_valid;
  logic              busy;
  logic              err;

  modport master (
    output req_valid, req_addr, req_len, req_mode, wrt_enable,
    input  req_ready, out, out_valid, busy, err
  );

  modport slave (
    input  req_valid, req_addr, req_len, req_mode, wrt_enable,
    output req_ready, out, out_valid, busy, err
  );

endinterface

// File: rtl/onehot_wr_sequencer_dec.sv
// Combinational ADDR_W -> 2**ADDR_W one-hot decoder with enable; zero latency.
// No flow control; output is all zeros when en is low.
module onehot_dec #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     en,
  output logic [(1<<ADDR_W)-1:0]   dec
);

  always_comb begin
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end

endmodule

// File: rtl/onehot_wr_sequencer.sv
// Registered one-hot write-enable sequencer (single / wrapping burst / broadcast if ONEHOT_WR_BROADCAST_EN); first beat 1 cycle after accept.
// Accepts only when idle; wrt_enable low stalls the sequence without consuming beats.
module onehot_wr_sequencer
  import onehot_wr_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_wr_sequencer_if.slave  bus
);

  localparam int OUT_W = 1 << ADDR_W;
  localparam int CNT_W = LEN_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, issue_addr;
  logic [CNT_W-1:0]  pend_q, pend_d, pend_start;
  logic [OUT_W-1:0]  out_q, out_d, dec;
  logic              out_valid_q, err_q, err_d;
  logic              accept, supported, issue;
  mode_e             req_mode;
`ifdef ONEHOT_WR_BROADCAST_EN
  logic              bcast_q, bcast_d, issue_bcast;
`endif

  assign req_mode = mode_e'(bus.req_mode);
  assign accept   = bus.req_valid && (state_q == ST_IDLE);

  always_comb begin
    supported = 1'b0;
    case (req_mode)
      MODE_SINGLE, MODE_BURST: supported = 1'b1;
`ifdef ONEHOT_WR_BROADCAST_EN
      MODE_BCAST:              supported = 1'b1;
`endif
      default:                 supported = 1'b0;
    endcase
  end

  // pend counts beats not yet issued, so a full 2**LEN_W burst needs one extra bit
  assign pend_start = (req_mode == MODE_BURST) ? CNT_W'(bus.req_len) + CNT_W'(1)
                                               : CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    err_d      = err_q;
    issue      = 1'b0;
    issue_addr = addr_q;
`ifdef ONEHOT_WR_BROADCAST_EN
    bcast_d     = bcast_q;
    issue_bcast = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (supported) begin
            state_d = ST_RUN;
            addr_d  = bus.req_addr;
            pend_d  = pend_start;
`ifdef ONEHOT_WR_BROADCAST_EN
            bcast_d = (req_mode == MODE_BCAST);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // stay in RUN while the last beat is on the output
        if (pend_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A beat is registered at this edge whenever work remains and the gate is open
    if ((state_d == ST_RUN) && (pend_d != '0) && bus.wrt_enable) begin
      issue      = 1'b1;
      issue_addr = addr_d;
      addr_d     = addr_d + ADDR_W'(1);
      pend_d     = pend_d - CNT_W'(1);
`ifdef ONEHOT_WR_BROADCAST_EN
      issue_bcast = bcast_d;
`endif
    end
  end

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
    .addr (issue_addr),
    .en   (issue),
    .dec  (dec)
  );

`ifdef ONEHOT_WR_BROADCAST_EN
  assign out_d = issue_bcast ? {OUT_W{1'b1}} : dec;
`else
  assign out_d = dec;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pend_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef ONEHOT_WR_BROADCAST_EN
      bcast_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= issue;
      err_q       <= err_d;
`ifdef ONEHOT_WR_BROADCAST_EN
      bcast_q     <= bcast_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_onehot_wr_sequencer.sv
// Bench for onehot_wr_sequencer: queue-based beat model checked every cycle, plus directed literal checks.
module tb_onehot_wr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  onehot_wr_sequencer_if #(.ADDR_W(4), .LEN_W(4)) bus ();

  onehot_wr_sequencer #(.ADDR_W(4), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mode_ok(input logic [1:0] m);
`ifdef ONEHOT_WR_BROADCAST_EN
    return (m != 2'b11);
`else
    return (m == 2'b00) || (m == 2'b01);
`endif
  endfunction

  // Model: an accepted request expands into its list of beat vectors; each open-gate edge pops one.
  logic [15:0] beats[$];
  logic [15:0] exp_out;
  bit          exp_vld, exp_busy, exp_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beats.delete();
      exp_out  = 16'h0;
      exp_vld  = 1'b0;
      exp_busy = 1'b0;
      exp_err  = 1'b0;
    end else begin
      if (!exp_busy && bus.req_valid) begin
        if (mode_ok(bus.req_mode)) begin
          int nb;
          nb = (bus.req_mode == 2'b01) ? int'(bus.req_len) + 1 : 1;
          for (int i = 0; i < nb; i++) begin
            if (bus.req_mode == 2'b10) beats.push_back(16'hFFFF);
            else beats.push_back(16'h0001 << ((int'(bus.req_addr) + i) % 16));
          end
        end else begin
          exp_err = 1'b1;
        end
      end
      if (bus.wrt_enable && beats.size() > 0) begin
        exp_out = beats.pop_front();
        exp_vld = 1'b1;
      end else begin
        exp_out = 16'h0;
        exp_vld = 1'b0;
      end
      exp_busy = (beats.size() > 0) || exp_vld;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_out",   32'(bus.out),       32'(exp_out));
      check("model_vld",   32'(bus.out_valid), 32'(exp_vld));
      check("model_busy",  32'(bus.busy),      32'(exp_busy));
      check("model_ready", 32'(bus.req_ready), 32'(!exp_busy));
      check("model_err",   32'(bus.err),       32'(exp_err));
    end
  end

  // Present a request at a negedge, hold until accepted; returns at the negedge of the first beat cycle.
  task automatic send(input logic [3:0] a, input logic [3:0] l, input logic [1:0] m);
    int guard;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_mode  = m;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'(guard), 32'(0));
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bit acc_prev;
    int r;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_mode   = 2'b00;
    bus.wrt_enable = 1'b1;
    acc_prev       = 1'b0;

    @(negedge clk);
    check("rst_out",   32'(bus.out),       32'h0);
    check("rst_vld",   32'(bus.out_valid), 32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_err",   32'(bus.err),       32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // single beat
    send(4'd5, 4'd0, 2'b00);
    check("single_out", 32'(bus.out), 32'h0020);
    check("single_vld", 32'(bus.out_valid), 32'h1);
    check("single_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    check("single_out0", 32'(bus.out), 32'h0);

    // burst wrapping 14 -> 1
    send(4'd14, 4'd3, 2'b01);
    check("wrap_b0", 32'(bus.out), 32'h4000);
    @(negedge clk); check("wrap_b1", 32'(bus.out), 32'h8000);
    @(negedge clk); check("wrap_b2", 32'(bus.out), 32'h0001);
    @(negedge clk); check("wrap_b3", 32'(bus.out), 32'h0002);
    @(negedge clk); check("wrap_idle", 32'(bus.req_ready), 32'h1);
    check("wrap_out0", 32'(bus.out), 32'h0);

    // stall: gate low for two cycles after the first beat
    send(4'd2, 4'd2, 2'b01);
    check("stall_b0", 32'(bus.out), 32'h0004);
    bus.wrt_enable = 1'b0;
    @(negedge clk); check("stall_gap0", 32'(bus.out), 32'h0);
    check("stall_busy", 32'(bus.busy), 32'h1);
    @(negedge clk); check("stall_gap1", 32'(bus.out), 32'h0);
    bus.wrt_enable = 1'b1;
    @(negedge clk); check("stall_b1", 32'(bus.out), 32'h0008);
    @(negedge clk); check("stall_b2", 32'(bus.out), 32'h0010);
    @(negedge clk); check("stall_done", 32'(bus.req_ready), 32'h1);

    // broadcast
    send(4'd0, 4'd0, 2'b10);
`ifdef ONEHOT_WR_BROADCAST_EN
    check("bcast_out", 32'(bus.out), 32'hFFFF);
    check("bcast_vld", 32'(bus.out_valid), 32'h1);
    @(negedge clk);
    check("bcast_out0", 32'(bus.out), 32'h0);
`else
    check("bcast_drop_out", 32'(bus.out), 32'h0);
    check("bcast_drop_err", 32'(bus.err), 32'h1);
    check("bcast_drop_ready", 32'(bus.req_ready), 32'h1);
`endif

    // reserved mode is dropped and sets the sticky error
    send(4'd3, 4'd0, 2'b11);
    check("rsvd_err", 32'(bus.err), 32'h1);
    check("rsvd_out", 32'(bus.out), 32'h0);
    check("rsvd_ready", 32'(bus.req_ready), 32'h1);

    // second request held while busy is taken only after the burst finishes
    bus.req_valid = 1'b1; bus.req_addr = 4'd0; bus.req_len = 4'd3; bus.req_mode = 2'b01;
    @(negedge clk);
    bus.req_addr = 4'd9; bus.req_len = 4'd0; bus.req_mode = 2'b00;
    check("hold_b0", 32'(bus.out), 32'h0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_notready", 32'(bus.req_ready), 32'h0);
    end
    @(negedge clk);
    check("hold_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("hold_second", 32'(bus.out), 32'h0200);
    check("hold_err_sticky", 32'(bus.err), 32'h1);
    @(negedge clk);

    // asynchronous reset mid-burst
    send(4'd4, 4'd7, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("arst_out",   32'(bus.out),       32'h0);
    check("arst_vld",   32'(bus.out_valid), 32'h0);
    check("arst_busy",  32'(bus.busy),      32'h0);
    check("arst_ready", 32'(bus.req_ready), 32'h1);
    check("arst_err",   32'(bus.err),       32'h0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic with requester hold discipline
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 300) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        bus.req_valid = 1'b0;
        acc_prev = 1'b0;
      end
      if (!(bus.req_valid && !acc_prev)) begin
        bus.req_valid = ($urandom_range(0, 99) < 40);
        bus.req_addr  = 4'($urandom);
        bus.req_len   = 4'($urandom);
        r = $urandom_range(0, 9);
        bus.req_mode  = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      end
      bus.wrt_enable = ($urandom_range(0, 99) < 75);
      acc_prev = bus.req_valid && bus.req_ready;
    end

    bus.req_valid = 1'b0;
    bus.wrt_enable = 1'b1;
    repeat (40) @(negedge clk);
    check("drain_idle", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
